game_flow_sequencer: RTL and testbench
======================================

// Module: game_flow_sequencer
// PURPOSE
//  Top-level game-flow controller for Breakout. Sequences GamePhysics: one update per
//  rendered frame, with a start/done handshake. Tracks lives, score and level, detects
//  ball-lost and field-cleared conditions, and issues ball/field restart pulses.
//  Sits between the VGA frame timing and GamePhysics, inside GameController.
// PARAMETERS
//  NUM_BLOCKS        72   width of BLOCK_STATE (1 = block present)
//  INIT_LIVES        3    lives loaded at new game (1..3)
//  BOTTOM_Y          470  ball lost when BALL_Y_PIXEL >= BOTTOM_Y
//  LOST_DELAY_FRAMES 60   frames held in LOST before re-serve (>=1)
//  SCORE_W           10   score width, saturating
// PORTS
//  CLK            in   1           system clock
//  RST_N          in   1           asynchronous, active-low reset
//  FRAME_RENDERED in   1           1-cycle pulse per completed frame
//  SW_PAUSE       in   1           level: freeze game
//  BTN_RELEASE    in   1           debounced level: start/serve button
//  UPDATE_DONE    in   1           1-cycle pulse from physics when its update finishes
//  BALL_Y_PIXEL   in   10          ball y position from physics
//  BLOCK_STATE    in   NUM_BLOCKS  block field from physics
//  START_UPDATE   out  1           1-cycle pulse: physics, run one update
//  BALL_RESET     out  1           1-cycle pulse: put ball back on paddle
//  FIELD_RESET    out  1           1-cycle pulse: restore all blocks and ball
//  GAME_STATE     out  3           current FSM state (encoding in package)
//  LIVES          out  2           remaining lives
//  SCORE          out  SCORE_W     blocks destroyed, saturating
//  LEVEL          out  4           fields cleared, wraps 15->0
//  OVERRUN        out  1           sticky: frame arrived while update outstanding
// BEHAVIOUR
//  Reset (async, RST_N=0): GAME_STATE=IDLE. All pulse outputs 0. LIVES, SCORE, LEVEL,
//   OVERRUN 0. Busy flag cleared. Takes effect mid-update; a later UPDATE_DONE is ignored.
//  Button: rel_edge = BTN_RELEASE & ~prev (prev registered). Ignored while SW_PAUSE=1.
//  Update handshake, states SERVE/PLAY only:
//   - START_UPDATE fires the cycle after FRAME_RENDERED if !SW_PAUSE and !busy.
//   - START_UPDATE sets busy; UPDATE_DONE clears it.
//   - FRAME_RENDERED with busy=1: frame dropped, OVERRUN<=1 (cleared only by reset).
//   - UPDATE_DONE and FRAME_RENDERED in the same cycle: done processed first, so the
//     start is issued (no overrun).
//  Score pipeline, on UPDATE_DONE:
//   - cycle+1: cleared = prev_blocks & ~BLOCK_STATE; prev_blocks <= BLOCK_STATE.
//   - cycle+2: SCORE += popcount(cleared), saturating at 2^SCORE_W-1.
//   - FIELD_RESET loads prev_blocks with all ones.
//  FSM:
//   IDLE -> SERVE on rel_edge. Same cycle: FIELD_RESET, LIVES=INIT_LIVES, SCORE=0, LEVEL=0.
//   SERVE -> PLAY on rel_edge. Physics launches the ball itself; updates continue.
//   PLAY, evaluated on UPDATE_DONE, first match wins:
//    1. BLOCK_STATE==0 -> WON.
//    2. BALL_Y_PIXEL>=BOTTOM_Y -> LIVES-1; if the result is 0 -> GAME_OVER, else LOST.
//   LOST: no updates. Counts FRAME_RENDERED pulses (frozen while paused).
//    At LOST_DELAY_FRAMES: BALL_RESET pulse -> SERVE.
//   WON -> SERVE on rel_edge: FIELD_RESET, LEVEL+1; LIVES and SCORE kept.
//   GAME_OVER -> SERVE on rel_edge: FIELD_RESET, LIVES=INIT_LIVES, SCORE=0, LEVEL=0.
//  Pause: state, counters and outputs hold; pulse outputs stay 0.
//   An outstanding UPDATE_DONE is still accepted.
//  A rel_edge held across state changes counts once; one edge never advances two states.
// STRUCTURE
//  breakout_pkg: game_state_t {IDLE=0,SERVE=1,PLAY=2,LOST=3,WON=4,GAME_OVER=5};
//   NUM_BLOCKS, SCREEN_H=480, BOTTOM_Y default.
//  Sub-module cleared_block_counter: registered NUM_BLOCKS-bit popcount (7-bit out),
//   fed the cleared mask, 1-cycle latency.
//  Top: FSM, busy/overrun logic, LOST frame counter, button edge register, score adder.
// TESTING
//  1 Reset mid-PLAY with busy=1: all outputs 0 at once, IDLE. A late UPDATE_DONE
//    causes no change.
//  2 IDLE, BTN_RELEASE 0->1: one FIELD_RESET, LIVES=3, SERVE. Three frames give three
//    START_UPDATEs, each answered by UPDATE_DONE 5 cycles later.
//  3 PLAY, frame while busy: no START_UPDATE, OVERRUN=1. Done and frame in the same
//    cycle: START_UPDATE next cycle.
//  4 PLAY, done with 3 bits cleared, then 5 more: SCORE 0->3->8. At SCORE=1020 with
//    5 cleared: SCORE=1023.
//  5 PLAY, LIVES=2, BALL_Y=470: LOST, LIVES=1. BALL_RESET after exactly 60 frames,
//    and 90 if paused for 30. Next loss: GAME_OVER, LIVES=0.
//  6 PLAY, BLOCK_STATE=0 with BALL_Y=475 in the same done: WON, LIVES unchanged.
//    rel_edge gives FIELD_RESET, LEVEL=1, SERVE.

Source files
------------

// File: rtl/game_flow_sequencer_pkg.sv
// game_flow_sequencer_pkg: shared game-flow state encoding and default playfield constants.
package game_flow_sequencer_pkg;
    localparam int NUM_BLOCKS = 72;
    localparam int SCREEN_H = 480;
    localparam int BOTTOM_Y = SCREEN_H - 10;
    localparam int INIT_LIVES = 3;
    localparam int LOST_DELAY_FRAMES = 60;
    localparam int SCORE_W = 10;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SERVE = 3'd1,
        PLAY = 3'd2,
        LOST = 3'd3,
        WON = 3'd4,
        GAME_OVER = 3'd5
    } game_state_t;
    function automatic logic in_update_phase(game_state_t s);
        return s == SERVE || s == PLAY;
    endfunction
endpackage

// File: rtl/game_flow_sequencer_if.sv
// game_flow_sequencer_if: handshake and field/ball signals between the sequencer and GamePhysics.
interface game_flow_sequencer_if #(
    parameter int NUM_BLOCKS = game_flow_sequencer_pkg::NUM_BLOCKS
);
    logic start_update;
    logic ball_reset;
    logic field_reset;
    logic update_done;
    logic [9:0] ball_y_pixel;
    logic [NUM_BLOCKS-1:0] block_state;
    modport master(
        output start_update, ball_reset, field_reset,
        input update_done, ball_y_pixel, block_state
    );
    modport slave(
        input start_update, ball_reset, field_reset,
        output update_done, ball_y_pixel, block_state
    );
endinterface

// File: rtl/game_flow_sequencer_cleared_block_counter.sv
// cleared_block_counter: registered popcount of the blocks cleared by one physics update.
module cleared_block_counter #(
    parameter int NUM_BLOCKS = 72
) (
    input logic clk,
    input logic rst_n,
    input logic valid,
    input logic [NUM_BLOCKS-1:0] mask,
    output logic [6:0] count,
    output logic count_valid
);
    logic [6:0] ones;
    always_comb begin
        ones = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) ones = ones + 7'(mask[i]);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            count_valid <= 1'b0;
        end else begin
            count <= valid ? ones : '0;
            count_valid <= valid;
        end
    end
endmodule

// File: rtl/game_flow_sequencer.sv
// game_flow_sequencer: Breakout game-flow FSM; paces physics once per frame and
// keeps lives, score and level.
module game_flow_sequencer import game_flow_sequencer_pkg::*; #(
    parameter int NUM_BLOCKS = game_flow_sequencer_pkg::NUM_BLOCKS,
    parameter int INIT_LIVES = game_flow_sequencer_pkg::INIT_LIVES,
    parameter int BOTTOM_Y = game_flow_sequencer_pkg::BOTTOM_Y,
    parameter int LOST_DELAY_FRAMES = game_flow_sequencer_pkg::LOST_DELAY_FRAMES,
    parameter int SCORE_W = game_flow_sequencer_pkg::SCORE_W
) (
    input logic clk,
    input logic rst_n,
    input logic frame_rendered,
    input logic sw_pause,
    input logic btn_release,
    game_flow_sequencer_if.master phys,
    output logic [2:0] game_state,
    output logic [1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic [3:0] level,
    output logic overrun
);
    localparam int CNT_W = $clog2(LOST_DELAY_FRAMES + 1);
    game_state_t state, state_nxt;
    logic btn_q, busy, start_q, ball_reset_q, field_reset_q;
    logic rel_edge, done_ok, frame_ok, lost_ball, lose_life, lost_last;
    logic start_nxt, overrun_nxt, field_rst_nxt, ball_rst_nxt, new_game;
    logic [CNT_W-1:0] lost_cnt;
    logic [NUM_BLOCKS-1:0] prev_blocks;
    logic [6:0] cleared_cnt;
    logic cleared_valid;
    logic [SCORE_W:0] score_sum;
    // A done only counts while an update is outstanding, so a stale one after reset is dropped.
    assign done_ok = phys.update_done & busy;
    assign rel_edge = btn_release & ~btn_q & ~sw_pause;
    assign frame_ok = frame_rendered & ~sw_pause;
    assign lost_ball = phys.ball_y_pixel >= 10'(BOTTOM_Y);
    assign lose_life = state == PLAY && done_ok && |phys.block_state && lost_ball;
    assign lost_last = frame_ok && lost_cnt == CNT_W'(LOST_DELAY_FRAMES - 1);
    assign start_nxt = frame_ok & (~busy | done_ok) & in_update_phase(state) & in_update_phase(state_nxt);
    assign overrun_nxt = frame_ok & busy & ~done_ok & in_update_phase(state);
    assign score_sum = {1'b0, score} + (SCORE_W + 1)'(cleared_cnt);
    always_comb begin
        state_nxt = state;
        field_rst_nxt = 1'b0;
        ball_rst_nxt = 1'b0;
        new_game = 1'b0;
        case (state)
            IDLE, GAME_OVER: begin
                state_nxt = rel_edge ? SERVE : state;
                field_rst_nxt = rel_edge;
                new_game = rel_edge;
            end
            SERVE: state_nxt = rel_edge ? PLAY : SERVE;
            PLAY: state_nxt = !done_ok ? PLAY : ~|phys.block_state ? WON :
                              !lost_ball ? PLAY : lives == 2'd1 ? GAME_OVER : LOST;
            LOST: begin
                state_nxt = lost_last ? SERVE : LOST;
                ball_rst_nxt = lost_last;
            end
            WON: begin
                state_nxt = rel_edge ? SERVE : WON;
                field_rst_nxt = rel_edge;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            btn_q <= 1'b0;
            busy <= 1'b0;
            start_q <= 1'b0;
            ball_reset_q <= 1'b0;
            field_reset_q <= 1'b0;
            overrun <= 1'b0;
            lost_cnt <= '0;
            prev_blocks <= '1;
            lives <= '0;
            score <= '0;
            level <= '0;
        end else begin
            state <= state_nxt;
            btn_q <= btn_release;
            start_q <= start_nxt;
            ball_reset_q <= ball_rst_nxt;
            field_reset_q <= field_rst_nxt;
            busy <= start_nxt | (busy & ~phys.update_done);
            overrun <= overrun | overrun_nxt;
            lost_cnt <= state != LOST ? '0 : lost_cnt + CNT_W'(frame_ok);
            prev_blocks <= field_rst_nxt ? '1 : done_ok ? phys.block_state : prev_blocks;
            lives <= new_game ? 2'(INIT_LIVES) : lose_life ? lives - 2'd1 : lives;
            score <= new_game ? '0 : !cleared_valid ? score :
                     score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            level <= new_game ? 4'd0 : field_rst_nxt ? level + 4'd1 : level;
        end
    end
    cleared_block_counter #(.NUM_BLOCKS(NUM_BLOCKS)) u_counter (
        .clk(clk),
        .rst_n(rst_n),
        .valid(done_ok),
        .mask(prev_blocks & ~phys.block_state),
        .count(cleared_cnt),
        .count_valid(cleared_valid)
    );
    assign phys.start_update = start_q;
    assign phys.ball_reset = ball_reset_q;
    assign phys.field_reset = field_reset_q;
    assign game_state = state;
endmodule

// File: tb/tb_game_flow_sequencer.sv
// tb_game_flow_sequencer: bench acting as GamePhysics with random block clears, checked
// against a transaction-level model of the game rules.
module tb_game_flow_sequencer;
    import game_flow_sequencer_pkg::*;
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;
    logic clk = 1'b0;
    logic rst_n, frame_rendered, sw_pause, btn_release;
    logic [2:0] game_state;
    logic [1:0] lives;
    logic [SCORE_W-1:0] score;
    logic [3:0] level;
    logic overrun;
    int checks = 0, errors = 0;
    int n_start = 0, n_ball = 0, n_field = 0;
    game_state_t m_state;
    int m_lives, m_score, m_level, m_overrun;
    logic [NUM_BLOCKS-1:0] field;
    int c, s0, b0;
    game_flow_sequencer_if phys();
    game_flow_sequencer dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_rendered(frame_rendered),
        .sw_pause(sw_pause),
        .btn_release(btn_release),
        .phys(phys),
        .game_state(game_state),
        .lives(lives),
        .score(score),
        .level(level),
        .overrun(overrun)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (phys.start_update) n_start++;
        if (phys.ball_reset) n_ball++;
        if (phys.field_reset) n_field++;
    end
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic check_model;
        check("state", int'(game_state), int'(m_state));
        check("lives", int'(lives), m_lives);
        check("score", int'(score), m_score);
        check("level", int'(level), m_level);
        check("overrun", int'(overrun), m_overrun);
    endtask
    task automatic press(input logic paused);
        int f0, exp_f;
        f0 = n_field;
        exp_f = 0;
        sw_pause = paused;
        btn_release = 1'b1;
        repeat (3) tick;
        btn_release = 1'b0;
        repeat (2) tick;
        sw_pause = 1'b0;
        if (!paused) begin
            case (m_state)
                IDLE, GAME_OVER: begin
                    m_state = SERVE;
                    m_lives = INIT_LIVES;
                    m_score = 0;
                    m_level = 0;
                    field = '1;
                    exp_f = 1;
                end
                SERVE: m_state = PLAY;
                WON: begin
                    m_state = SERVE;
                    m_level = (m_level + 1) % 16;
                    field = '1;
                    exp_f = 1;
                end
                default: ;
            endcase
        end
        check("field_reset", n_field - f0, exp_f);
        check_model;
    endtask
    task automatic do_update(input int clr, input int y);
        int s, k, idx;
        s = n_start;
        frame_rendered = 1'b1;
        tick;
        frame_rendered = 1'b0;
        for (int i = 0; i < 4 && n_start == s; i++) tick;
        check("start_update", n_start - s, 1);
        repeat (4) tick;
        k = 0;
        while (k < clr) begin
            idx = $urandom_range(0, NUM_BLOCKS - 1);
            if (field[idx]) begin
                field[idx] = 1'b0;
                k++;
            end
        end
        phys.block_state = field;
        phys.ball_y_pixel = 10'(y);
        phys.update_done = 1'b1;
        tick;
        phys.update_done = 1'b0;
        repeat (4) tick;
        m_score = (m_score + clr > SCORE_MAX) ? SCORE_MAX : m_score + clr;
        if (m_state == PLAY) begin
            if (field == '0) m_state = WON;
            else if (y >= BOTTOM_Y) begin
                m_lives--;
                m_state = (m_lives == 0) ? GAME_OVER : LOST;
            end
        end
        check_model;
    endtask
    task automatic lost_frames(input int n, input logic paused);
        sw_pause = paused;
        repeat (n) begin
            frame_rendered = 1'b1;
            tick;
            frame_rendered = 1'b0;
            tick;
        end
        sw_pause = 1'b0;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end
    initial begin
        rst_n = 1'b0;
        frame_rendered = 1'b0;
        sw_pause = 1'b0;
        btn_release = 1'b0;
        phys.update_done = 1'b0;
        phys.ball_y_pixel = '0;
        phys.block_state = '1;
        field = '1;
        m_state = IDLE;
        m_lives = 0;
        m_score = 0;
        m_level = 0;
        m_overrun = 0;
        repeat (3) tick;
        check_model;
        check("rst_start", int'(phys.start_update), 0);
        check("rst_field", int'(phys.field_reset), 0);
        rst_n = 1'b1;
        tick;
        press(1'b0);
        repeat (3) do_update(0, 0);
        press(1'b0);
        s0 = n_start;
        frame_rendered = 1'b1;
        tick;
        frame_rendered = 1'b0;
        repeat (2) tick;
        check("start_first", n_start - s0, 1);
        frame_rendered = 1'b1;
        tick;
        frame_rendered = 1'b0;
        repeat (3) tick;
        check("start_dropped", n_start - s0, 1);
        check("overrun_set", int'(overrun), 1);
        m_overrun = 1;
        phys.block_state = field;
        phys.ball_y_pixel = '0;
        phys.update_done = 1'b1;
        frame_rendered = 1'b1;
        tick;
        phys.update_done = 1'b0;
        frame_rendered = 1'b0;
        check("start_after_done", int'(phys.start_update), 1);
        repeat (4) tick;
        phys.update_done = 1'b1;
        tick;
        phys.update_done = 1'b0;
        repeat (4) tick;
        check("start_total", n_start - s0, 2);
        check_model;
        do_update(3, 100);
        do_update(5, 100);
        while (m_score < 1020) begin
            c = $urandom_range(1, 12);
            if (c > 1020 - m_score) c = 1020 - m_score;
            if (c > $countones(field)) c = $countones(field);
            do_update(c, $urandom_range(0, BOTTOM_Y - 1));
            if (m_state == WON) begin
                press(1'b0);
                press(1'b0);
            end
        end
        while ($countones(field) < 5) begin
            do_update($countones(field), 100);
            press(1'b0);
            press(1'b0);
        end
        do_update(5, 100);
        check("score_saturated", int'(score), SCORE_MAX);
        do_update(0, BOTTOM_Y);
        b0 = n_ball;
        lost_frames(LOST_DELAY_FRAMES - 1, 1'b0);
        check("ball_reset_early", n_ball - b0, 0);
        check("still_lost", int'(game_state), int'(LOST));
        lost_frames(1, 1'b0);
        check("ball_reset", n_ball - b0, 1);
        m_state = SERVE;
        check_model;
        press(1'b0);
        do_update(0, 500);
        b0 = n_ball;
        lost_frames(30, 1'b1);
        lost_frames(LOST_DELAY_FRAMES - 1, 1'b0);
        check("ball_reset_paused_early", n_ball - b0, 0);
        lost_frames(1, 1'b0);
        check("ball_reset_paused", n_ball - b0, 1);
        m_state = SERVE;
        check_model;
        press(1'b1);
        press(1'b0);
        do_update(0, BOTTOM_Y);
        press(1'b0);
        press(1'b0);
        do_update(4, 100);
        do_update($countones(field), 475);
        press(1'b0);
        press(1'b0);
        do_update(2, 100);
        frame_rendered = 1'b1;
        tick;
        frame_rendered = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        m_state = IDLE;
        m_lives = 0;
        m_score = 0;
        m_level = 0;
        m_overrun = 0;
        check_model;
        check("rst_mid_start", int'(phys.start_update), 0);
        tick;
        rst_n = 1'b1;
        tick;
        field[0] = 1'b0;
        field[1] = 1'b0;
        phys.block_state = field;
        phys.update_done = 1'b1;
        tick;
        phys.update_done = 1'b0;
        s0 = n_start;
        frame_rendered = 1'b1;
        tick;
        frame_rendered = 1'b0;
        repeat (4) tick;
        check("idle_no_start", n_start - s0, 0);
        check_model;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
